// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings, the default operand width and the bit-counter width helper.
package serial_add_ctrl_pkg;

  // Default operand width when the instantiating scope does not override W.
  localparam int SERIAL_ADD_W = 4;

  // Controller states; encodings are fixed so waveforms and checkers can
  // decode the debug state output directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter needs clog2(W) bits, but never fewer than one.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// 1-bit full adder shared by the team's arithmetic exercises; the serial
// controller time-shares a single instance of it.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  // Plain sum/majority-carry equations.
  always_comb begin
    s_o  = a_i ^ b_i ^ ci_i;
    co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two W-bit operands LSB first, one bit
// per clock, through one full_adder. Operands are latched on an accepted
// start; the sum is assembled in a shift register and published with a
// one-cycle done pulse, W+1 cycles after the start is sampled.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow
// output ovf, loaded and held alongside sum.
//
// Handshake: start is a request sampled only in IDLE or DONE (ignored in
// RUN, never queued); busy is high for exactly the W RUN cycles; done is
// high for exactly the one DONE cycle, and sum/cout(/ovf) are valid from
// that cycle until the next result is published or reset.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int W = SERIAL_ADD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic         ovf,
`endif
  output state_e       state_o
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e          state_q,  state_d;
  logic [W-1:0]    a_sh_q,   a_sh_d;
  logic [W-1:0]    b_sh_q,   b_sh_d;
  logic [W-1:0]    sum_sh_q, sum_sh_d;
  logic [W-1:0]    sum_q,    sum_d;
  logic            carry_q,  carry_d;
  logic            cout_q,   cout_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic            ovf_q,    ovf_d;
`endif

  logic            fa_sum;
  logic            fa_cout;
  logic            accept;
  logic [W-1:0]    sum_next;

  // The single shared adder always looks at the current LSBs and carry.
  full_adder u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_sum),
    .co_o (fa_cout)
  );

  // Sum shift register with this cycle's bit inserted at the top; after
  // W shifts the LSB of the result has reached bit 0.
  always_comb begin
    sum_next = (sum_sh_q >> 1) | (W'(fa_sum) << (W - 1));
  end

  // Next-state and datapath control; defaults hold every register.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    accept   = 1'b0;

    case (state_q)
      IDLE: begin
        accept = start;
      end
      RUN: begin
        sum_sh_d = sum_next;
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the result including the bit added now.
          state_d = DONE;
          sum_d   = sum_next;
          cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB, fa_cout the carry out.
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end
      DONE: begin
        // A start here chains straight into the next operation.
        accept = start;
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d  = RUN;
      a_sh_d   = a;
      b_sh_d   = b;
      carry_d  = cin;
      cnt_d    = '0;
      sum_sh_d = '0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Status and result outputs decoded from registered state.
  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    sum     = sum_q;
    cout    = cout_q;
    state_o = state_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf     = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a W=4 instance for directed and
// random operations and a W=1 instance for the exhaustive single-bit case.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int W4     = 4;
  localparam int BUDGET = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // W=4 instance signals
  logic          start4 = 1'b0;
  logic [W4-1:0] a4 = '0, b4 = '0;
  logic          cin4 = 1'b0;
  logic          busy4, done4, cout4;
  logic [W4-1:0] sum4;
  state_e        st4;
  // W=1 instance signals
  logic          start1 = 1'b0;
  logic [0:0]    a1 = '0, b1 = '0;
  logic          cin1 = 1'b0;
  logic          busy1, done1, cout1;
  logic [0:0]    sum1;
  state_e        st1;
`ifdef SERIAL_ADD_OVF_EN
  logic          ovf4, ovf1;
`endif

  serial_add_ctrl #(.W(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf4),
`endif
    .state_o(st4)
  );

  serial_add_ctrl #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf1),
`endif
    .state_o(st1)
  );

  // ---------------- scoreboard ----------------
  // Entries are {ovf, cout, sum} for the W=4 instance, in start order.
  logic [W4+1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: unsigned sum and carry from plain addition, overflow from
  // whether the signed two's-complement sum leaves the representable range.
  function automatic logic [W4+1:0] ref_add(input int w, input int a, input int b, input int c);
    int total, sa, sb, s;
    logic [W4+1:0] r;
    total = a + b + c;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    s  = sa + sb + c;
    r  = '0;
    r[W4-1:0] = W4'(total % (1 << w));
    r[W4]     = ((total >> w) & 1) != 0;
    r[W4+1]   = (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op4(input int a, input int b, input int c);
    a4 = W4'(a);
    b4 = W4'(b);
    cin4 = c[0];
    start4 = 1'b1;
    exp_q.push_back(ref_add(W4, a, b, c));
  endtask

  // Runs until done, checking latency, busy length, result hold during RUN
  // and the result. pulse_at>0 pulses start mid-RUN (must be ignored);
  // scramble changes operands after acceptance (must have no effect).
  task automatic finish_op4(input string tag, input int pulse_at, input bit scramble);
    int n, busy_n;
    logic [W4-1:0] sum_hold;
    logic cout_hold, held;
    logic [W4+1:0] e;
    n = 0; busy_n = 0; held = 1'b1;
    sum_hold = sum4; cout_hold = cout4;
    do begin
      tick();
      n++;
      if (n == 1) begin
        start4 = 1'b0;
        if (scramble) begin
          a4 = W4'($urandom); b4 = W4'($urandom); cin4 = 1'($urandom);
        end
      end
      if (pulse_at > 0 && n == pulse_at) begin
        a4 = ~a4; start4 = 1'b1;
      end
      if (pulse_at > 0 && n == pulse_at + 1) start4 = 1'b0;
      if (busy4) busy_n++;
      if (!done4 && (sum4 !== sum_hold || cout4 !== cout_hold)) held = 1'b0;
    end while (!done4 && n < BUDGET);
    check({tag, "_done_seen"}, done4, 1'b1);
    check({tag, "_latency"}, n, W4 + 1);
    check({tag, "_busy_cycles"}, busy_n, W4);
    check({tag, "_held_in_run"}, held, 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, sum4, e[W4-1:0]);
      check({tag, "_cout"}, cout4, e[W4]);
`ifdef SERIAL_ADD_OVF_EN
      check({tag, "_ovf"}, ovf4, e[W4+1]);
`endif
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int n, dones;
    logic [W4+1:0] e;

    // Reset held 2 cycles with start asserted: nothing may start.
    rst_n = 1'b0; start4 = 1'b1; start1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_busy", busy4, 1'b0);
      check("rst_done", done4, 1'b0);
      check("rst_sum", sum4, 0);
      check("rst_cout", cout4, 1'b0);
      check("rst_state", st4, IDLE);
      check("rst_busy_w1", busy1, 1'b0);
    end
    rst_n = 1'b1; start4 = 1'b0; start1 = 1'b0;
    tick();
    check("post_rst_busy", busy4, 1'b0);
    check("post_rst_state", st4, IDLE);

    // Basic add 5+3: result 8, signed overflow.
    start_op4(5, 3, 0);
    finish_op4("basic", 0, 1'b0);
    tick();
    check("done_single_pulse", done4, 1'b0);
    check("back_to_idle", st4, IDLE);

    // Carry out: F+1+1 = 0x11, then the result must stay put.
    start_op4(15, 1, 1);
    finish_op4("carry", 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("carry_hold_sum", sum4, 1);
      check("carry_hold_cout", cout4, 1'b1);
    end

    // Exhaustive W=1: done two cycles after each start.
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      start1 = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
        if (n == 1) start1 = 1'b0;
      end while (!done1 && n < BUDGET);
      e = ref_add(1, (i >> 2) & 1, (i >> 1) & 1, i & 1);
      check("w1_latency", n, 2);
      check("w1_result", {cout1, sum1}, {e[W4], e[0]});
`ifdef SERIAL_ADD_OVF_EN
      check("w1_ovf", ovf1, e[W4+1]);
`endif
      tick();
    end

    // Back-to-back: start in the DONE cycle chains without an idle cycle.
    start_op4(9, 4, 0);
    finish_op4("b2b_first", 0, 1'b0);
    start_op4(12, 7, 1);
    finish_op4("b2b_second", 0, 1'b0);
    tick();

    // Start pulsed mid-RUN is ignored: one done only, first result kept.
    start_op4(2, 9, 0);
    finish_op4("ignored_start", 2, 1'b0);
    dones = 0;
    for (int i = 0; i < W4 + 2; i++) begin
      tick();
      if (done4 || busy4) dones++;
    end
    check("ignored_no_extra_op", dones, 0);

    // Reset after two RUN cycles aborts with no done.
    a4 = 4'd7; b4 = 4'd6; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", busy4, 1'b0);
    check("abort_done", done4, 1'b0);
    check("abort_sum", sum4, 0);
    check("abort_cout", cout4, 1'b0);
    check("abort_state", st4, IDLE);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < W4 + 3; i++) begin
      tick();
      if (done4) dones++;
    end
    check("abort_no_done", dones, 0);
    start_op4(9, 9, 1);
    finish_op4("after_abort", 0, 1'b0);

    // Random operations, random gaps or back-to-back, operands scrambled
    // after acceptance.
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 1) == 0) begin
        int gap;
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) tick();
      end
      start_op4($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      finish_op4("random", 0, 1'b1);
    end
    tick();
    check("final_done_low", done4, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
